laggy_prefix_arbiter: RTL and testbench
=======================================

// Module: laggy_prefix_arbiter
// PURPOSE
//  Shares one laggy_prefix engine between NUM_REQ fast-prefix lanes. Each cycle it picks one
//  valid (position, weight) request round-robin and pushes it into the engine input FIFO.
//  It tags every issued request with its requester ID in an in-order tag FIFO.
//  When the engine returns slow_valid, it routes offset/position/weight back to the owning lane.
// PARAMETERS
//  NUM_REQ        4    number of requesting lanes (>=2)
//  BITMASK_WIDTH  128  bitmask width; POS_W = $clog2(BITMASK_WIDTH)
//  WEIGHT_WIDTH   8    weight width
//  TAG_DEPTH      8    max outstanding requests (power of 2); IDW = $clog2(NUM_REQ)
// PORTS
//  clk                  in   1                  clock
//  rst                  in   1                  synchronous reset, active-high
//  req_valid            in   NUM_REQ            lane i has a request
//  req_position         in   NUM_REQ*POS_W      lane i matched position, slice [i*POS_W +: POS_W]
//  req_weight           in   NUM_REQ*WEIGHT_WIDTH lane i weight, sliced likewise
//  req_ready            out  NUM_REQ            one-hot grant; transfer = req_valid[i] & req_ready[i]
//  flush                in   1                  stop granting, drain outstanding
//  lp_valid_match       out  1                  to engine valid_match
//  lp_matched_position  out  POS_W              to engine matched_position
//  lp_matched_weight    out  WEIGHT_WIDTH       to engine matched_weight
//  lp_fifo_full         in   1                  engine fifo_mp_full | fifo_weight_full
//  lp_slow_valid        in   1                  engine result strobe
//  lp_slow_offset       in   POS_W              engine slow_offset
//  lp_current_position  in   POS_W              engine current_position
//  lp_current_weight    in   WEIGHT_WIDTH       engine current_weight
//  res_valid            out  1                  registered result strobe
//  res_id               out  IDW                owning lane
//  res_offset/res_position/res_weight  out  POS_W/POS_W/WEIGHT_WIDTH  registered result
//  outstanding          out  $clog2(TAG_DEPTH)+1  issued, not yet returned
//  busy                 out  1                  outstanding != 0
//  flush_done           out  1                  1-cycle pulse: flush drained
//  err_orphan           out  1                  sticky: slow_valid arrived with tag FIFO empty
// BEHAVIOUR
//  - Reset: all registered outputs 0, rr_ptr=0, tag FIFO empty, outstanding=0, FSM=IDLE.
//    Reset mid-operation discards all tags. The engine shares rst and is cleared with it.
//  - can_issue = !lp_fifo_full && outstanding<TAG_DEPTH && state!=FLUSH.
//  - Grant (combinational): if can_issue, the first i with req_valid[i], searching from rr_ptr
//    upward mod NUM_REQ. req_ready = onehot(i), otherwise 0.
//    req_ready never depends on req_valid of the granted lane only; it may assert only with it.
//  - lp_valid_match = |req_ready. lp_matched_* is a combinational mux of the granted lane.
//    Zero added latency on issue.
//  - On a grant to k: rr_ptr <= (k+1) mod NUM_REQ, and k is pushed to the tag FIFO. No grant: rr_ptr held.
//  - On lp_slow_valid with tag FIFO non-empty:
//    - Next cycle: res_valid=1, res_id=tag head, and res_offset/position/weight=lp_* (1-cycle latency).
//    - The head is popped.
//  - On lp_slow_valid with tag FIFO empty: err_orphan<=1 (sticky until rst), no res_valid.
//  - outstanding: +1 on grant, -1 on valid pop. Both in one cycle: unchanged; tag push and pop
//    both occur. At TAG_DEPTH, a result plus a new request in the same cycle: still no grant that
//    cycle (uses the registered count).
//  - FSM:
//    - IDLE: enters BUSY on a grant. flush -> pulse flush_done next cycle, stay IDLE.
//    - BUSY: goes to IDLE when outstanding reaches 0 with no grant; goes to FLUSH on flush.
//    - FLUSH: no grants. When outstanding==0 -> flush_done=1 for 1 cycle -> IDLE.
//      flush is level; it is sampled only in IDLE/BUSY.
//  - Results return in engine order, which equals issue order; no reordering buffer.
// TESTING
//  - Reset: assert rst 2 cycles during traffic -> all outputs 0, outstanding=0, err_orphan=0.
//  - Single lane: lane 2 issues pos=37 w=0x5A -> lp_valid_match same cycle. Engine returns offset=9
//    -> next cycle res_valid=1, res_id=2, res_offset=9, res_position=37, res_weight=0x5A.
//  - Round-robin: all 4 lanes valid for 8 cycles, engine never full -> grant order 0,1,2,3,0,1,2,3;
//    result ids returned in the same order.
//  - Back-pressure: hold lp_fifo_full=1 for 5 cycles with lanes valid -> req_ready=0 throughout.
//    Release -> grant resumes at the saved rr_ptr.
//  - Credit limit: issue 8 requests with no results -> outstanding=8, no 9th grant.
//    A result plus a pending request in the same cycle -> outstanding=7 next cycle, grant the cycle after.
//  - Flush/orphan: flush with 3 outstanding -> no grants, flush_done after 3rd result.
//    Inject lp_slow_valid when empty -> err_orphan=1 and stays 1.

Source files
------------

// File: rtl/laggy_prefix_arbiter.sv
// laggy_prefix_arbiter
// Shares a single laggy_prefix engine between NUM_REQ fast-prefix lanes.
// Each cycle one valid (position, weight) request is granted round-robin and
// forwarded to the engine input with no added latency. The granted lane ID is
// pushed into an in-order tag FIFO. The engine answers in issue order, so each
// slow_valid result is paired with the tag at the FIFO head and returned,
// registered, with that owning lane ID.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req_valid / o_req_ready    per-lane request valid and one-hot grant
//   i_req_position/i_req_weight  per-lane packed request payloads
//   i_flush                      stop granting and drain outstanding requests
//   o_lp_valid_match, o_lp_matched_position, o_lp_matched_weight
//                                request towards the engine
//   i_lp_fifo_full               engine input FIFOs cannot accept a request
//   i_lp_slow_valid, i_lp_slow_offset, i_lp_current_position,
//   i_lp_current_weight          result returned by the engine
//   o_res_valid, o_res_id, o_res_offset, o_res_position, o_res_weight
//                                registered result routed to the owning lane
//   o_outstanding, o_busy        in-flight request count and non-zero flag
//   o_flush_done                 one-cycle pulse once a flush has drained
//   o_err_orphan                 sticky: result arrived with no tag pending
module laggy_prefix_arbiter #(
  parameter  int NUM_REQ       = 4,
  parameter  int BITMASK_WIDTH = 128,
  parameter  int WEIGHT_WIDTH  = 8,
  parameter  int TAG_DEPTH     = 8,
  localparam int POS_W         = $clog2(BITMASK_WIDTH),
  localparam int IDW           = $clog2(NUM_REQ),
  localparam int PTR_W         = $clog2(TAG_DEPTH),
  localparam int CNT_W         = $clog2(TAG_DEPTH) + 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*POS_W-1:0]        i_req_position,
  input  logic [NUM_REQ*WEIGHT_WIDTH-1:0] i_req_weight,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic                            i_flush,
  output logic                            o_lp_valid_match,
  output logic [POS_W-1:0]                o_lp_matched_position,
  output logic [WEIGHT_WIDTH-1:0]         o_lp_matched_weight,
  input  logic                            i_lp_fifo_full,
  input  logic                            i_lp_slow_valid,
  input  logic [POS_W-1:0]                i_lp_slow_offset,
  input  logic [POS_W-1:0]                i_lp_current_position,
  input  logic [WEIGHT_WIDTH-1:0]         i_lp_current_weight,
  output logic                            o_res_valid,
  output logic [IDW-1:0]                  o_res_id,
  output logic [POS_W-1:0]                o_res_offset,
  output logic [POS_W-1:0]                o_res_position,
  output logic [WEIGHT_WIDTH-1:0]         o_res_weight,
  output logic [CNT_W-1:0]                o_outstanding,
  output logic                            o_busy,
  output logic                            o_flush_done,
  output logic                            o_err_orphan
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FLUSH
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_flush_done;
  logic                    w_flush_done_next;
  logic [IDW-1:0]          r_rr_ptr;
  logic [CNT_W-1:0]        r_outstanding;
  logic [IDW-1:0]          r_tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic                    r_res_valid;
  logic [IDW-1:0]          r_res_id;
  logic [POS_W-1:0]        r_res_offset;
  logic [POS_W-1:0]        r_res_position;
  logic [WEIGHT_WIDTH-1:0] r_res_weight;
  logic                    r_err_orphan;

  logic                    w_can_issue;
  logic                    w_grant;
  logic [IDW-1:0]          w_grant_idx;
  logic [IDW-1:0]          w_lane;
  logic [IDW-1:0]          w_rr_next;
  logic                    w_pop;
  logic                    w_orphan;

  // The credit check uses the registered count, so a result arriving while
  // full does not open a slot until the following cycle.
  assign w_can_issue = !i_lp_fifo_full &&
                       (r_outstanding < CNT_W'(TAG_DEPTH)) &&
                       (r_state != ST_FLUSH);

  // Round-robin search starting at r_rr_ptr; the first valid lane found wins.
  always_comb begin
    w_grant     = 1'b0;
    w_grant_idx = '0;
    w_lane      = '0;
    o_req_ready = '0;
    if (w_can_issue) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        w_lane = IDW'((int'(r_rr_ptr) + j) % NUM_REQ);
        if (!w_grant && i_req_valid[w_lane]) begin
          w_grant     = 1'b1;
          w_grant_idx = w_lane;
        end
      end
    end
    if (w_grant) begin
      o_req_ready[w_grant_idx] = 1'b1;
    end
  end

  // Forward the granted lane's payload straight to the engine.
  always_comb begin
    o_lp_matched_position = '0;
    o_lp_matched_weight   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant && (w_grant_idx == IDW'(j))) begin
        o_lp_matched_position = i_req_position[j*POS_W +: POS_W];
        o_lp_matched_weight   = i_req_weight[j*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
  end

  assign o_lp_valid_match = w_grant;

  // Wrap explicitly so non-power-of-two lane counts stay in range.
  assign w_rr_next = (int'(w_grant_idx) == NUM_REQ - 1) ? '0 : w_grant_idx + 1'b1;

  assign w_pop    = i_lp_slow_valid && (r_outstanding != '0);
  assign w_orphan = i_lp_slow_valid && (r_outstanding == '0);

  // Tag storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_grant) begin
      r_tag_mem[r_wr_ptr] <= w_grant_idx;
    end
  end

  // Arbitration pointer, tag FIFO pointers, credit count and result register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_outstanding  <= '0;
      r_res_valid    <= 1'b0;
      r_res_id       <= '0;
      r_res_offset   <= '0;
      r_res_position <= '0;
      r_res_weight   <= '0;
      r_err_orphan   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_rr_ptr <= w_rr_next;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr       <= r_rd_ptr + 1'b1;
        r_res_id       <= r_tag_mem[r_rd_ptr];
        r_res_offset   <= i_lp_slow_offset;
        r_res_position <= i_lp_current_position;
        r_res_weight   <= i_lp_current_weight;
      end
      r_res_valid <= w_pop;
      case ({w_grant, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_orphan) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

  // FSM state register and the registered flush_done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_flush_done <= w_flush_done_next;
    end
  end

  // In IDLE a grant takes precedence over a flush request; a flush with
  // nothing in flight just acknowledges on the next cycle.
  always_comb begin
    w_state_next      = r_state;
    w_flush_done_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_next = ST_BUSY;
        end else if (i_flush) begin
          w_flush_done_next = 1'b1;
        end
      end
      ST_BUSY: begin
        if (i_flush) begin
          w_state_next = ST_FLUSH;
        end else if (!w_grant && (r_outstanding == '0)) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (r_outstanding == '0) begin
          w_flush_done_next = 1'b1;
          w_state_next      = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_res_valid    = r_res_valid;
  assign o_res_id       = r_res_id;
  assign o_res_offset   = r_res_offset;
  assign o_res_position = r_res_position;
  assign o_res_weight   = r_res_weight;
  assign o_outstanding  = r_outstanding;
  assign o_busy         = (r_outstanding != '0);
  assign o_flush_done   = r_flush_done;
  assign o_err_orphan   = r_err_orphan;

endmodule

// File: tb/tb_laggy_prefix_arbiter.sv
// tb_laggy_prefix_arbiter
// Directed bench for laggy_prefix_arbiter with 4 lanes, 7-bit positions,
// 8-bit weights and 8 tags. The bench plays the engine itself by driving
// slow_valid and the result fields directly.
module tb_laggy_prefix_arbiter;

  localparam int NumReq  = 4;
  localparam int PosW    = 7;
  localparam int WeightW = 8;
  localparam int CntW    = 4;

  logic                      clk;
  logic                      rst;
  logic [NumReq-1:0]         reqValid;
  logic [NumReq*PosW-1:0]    reqPosition;
  logic [NumReq*WeightW-1:0] reqWeight;
  logic [NumReq-1:0]         reqReady;
  logic                      flush;
  logic                      lpValidMatch;
  logic [PosW-1:0]           lpMatchedPosition;
  logic [WeightW-1:0]        lpMatchedWeight;
  logic                      lpFifoFull;
  logic                      lpSlowValid;
  logic [PosW-1:0]           lpSlowOffset;
  logic [PosW-1:0]           lpCurrentPosition;
  logic [WeightW-1:0]        lpCurrentWeight;
  logic                      resValid;
  logic [1:0]                resId;
  logic [PosW-1:0]           resOffset;
  logic [PosW-1:0]           resPosition;
  logic [WeightW-1:0]        resWeight;
  logic [CntW-1:0]           outstanding;
  logic                      busy;
  logic                      flushDone;
  logic                      errOrphan;

  int checkCount = 0;
  int errorCount = 0;

  laggy_prefix_arbiter #(
    .NUM_REQ      (NumReq),
    .BITMASK_WIDTH(128),
    .WEIGHT_WIDTH (WeightW),
    .TAG_DEPTH    (8)
  ) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_req_valid          (reqValid),
    .i_req_position       (reqPosition),
    .i_req_weight         (reqWeight),
    .o_req_ready          (reqReady),
    .i_flush              (flush),
    .o_lp_valid_match     (lpValidMatch),
    .o_lp_matched_position(lpMatchedPosition),
    .o_lp_matched_weight  (lpMatchedWeight),
    .i_lp_fifo_full       (lpFifoFull),
    .i_lp_slow_valid      (lpSlowValid),
    .i_lp_slow_offset     (lpSlowOffset),
    .i_lp_current_position(lpCurrentPosition),
    .i_lp_current_weight  (lpCurrentWeight),
    .o_res_valid          (resValid),
    .o_res_id             (resId),
    .o_res_offset         (resOffset),
    .o_res_position       (resPosition),
    .o_res_weight         (resWeight),
    .o_outstanding        (outstanding),
    .o_busy               (busy),
    .o_flush_done         (flushDone),
    .o_err_orphan         (errOrphan)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs shortly after the clock edge, then settle.
  task automatic applyStimulus(input logic [3:0] valid, input logic full,
                               input logic flushIn, input logic slow,
                               input logic [6:0] offset, input logic [6:0] curPos,
                               input logic [7:0] curWeight);
    reqValid          = valid;
    lpFifoFull        = full;
    flush             = flushIn;
    lpSlowValid       = slow;
    lpSlowOffset      = offset;
    lpCurrentPosition = curPos;
    lpCurrentWeight   = curWeight;
    #1;
  endtask

  task automatic setLane(input int lane, input logic [6:0] pos, input logic [7:0] weight);
    reqPosition[lane*PosW +: PosW]       = pos;
    reqWeight[lane*WeightW +: WeightW]   = weight;
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    reqPosition = '0;
    reqWeight   = '0;
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);

    // Power-on reset.
    nextCycle();
    nextCycle();
    checkOutput("rstOutstanding", 32'(outstanding), 32'd0);
    checkOutput("rstResValid", 32'(resValid), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstFlushDone", 32'(flushDone), 32'd0);
    checkOutput("rstErrOrphan", 32'(errOrphan), 32'd0);
    rst = 1'b0;

    // Single lane: lane 2 issues pos 37, weight 0x5A; engine returns offset 9.
    setLane(2, 7'd37, 8'h5A);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    checkOutput("singleReady", 32'(reqReady), 32'h4);
    checkOutput("singleLpValid", 32'(lpValidMatch), 32'd1);
    checkOutput("singleLpPos", 32'(lpMatchedPosition), 32'd37);
    checkOutput("singleLpWeight", 32'(lpMatchedWeight), 32'h5A);
    nextCycle();
    checkOutput("singleOutstanding", 32'(outstanding), 32'd1);
    checkOutput("singleBusy", 32'(busy), 32'd1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 7'd9, 7'd37, 8'h5A);
    checkOutput("singleNoReady", 32'(reqReady), 32'h0);
    nextCycle();
    checkOutput("singleResValid", 32'(resValid), 32'd1);
    checkOutput("singleResId", 32'(resId), 32'd2);
    checkOutput("singleResOffset", 32'(resOffset), 32'd9);
    checkOutput("singleResPos", 32'(resPosition), 32'd37);
    checkOutput("singleResWeight", 32'(resWeight), 32'h5A);
    checkOutput("singleDrained", 32'(outstanding), 32'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    nextCycle();
    checkOutput("singleResClear", 32'(resValid), 32'd0);

    // Reset during traffic: pointer now at 3, so lanes 3 then 0 are granted.
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    checkOutput("midRstReady", 32'(reqReady), 32'h8);
    nextCycle();
    nextCycle();
    checkOutput("midRstOutstanding", 32'(outstanding), 32'd2);
    rst = 1'b1;
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b1, 7'd3, 7'd3, 8'd3);
    nextCycle();
    nextCycle();
    checkOutput("midRstCount", 32'(outstanding), 32'd0);
    checkOutput("midRstResValid", 32'(resValid), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstFlushDone", 32'(flushDone), 32'd0);
    checkOutput("midRstErrOrphan", 32'(errOrphan), 32'd0);
    rst = 1'b0;
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    checkOutput("midRstPtr", 32'(reqReady), 32'h1);
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    nextCycle();

    // Round-robin: all lanes valid for 8 cycles fills all 8 credits.
    for (int k = 0; k < NumReq; k++) begin
      setLane(k, 7'(10 + k), 8'(8'hA0 + k));
    end
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
      checkOutput("rrReady", 32'(reqReady), 32'(1 << (c % 4)));
      checkOutput("rrLpPos", 32'(lpMatchedPosition), 32'(10 + (c % 4)));
      nextCycle();
      checkOutput("rrOutstanding", 32'(outstanding), 32'(c + 1));
    end

    // Credit limit: no 9th grant, and a result frees a slot only next cycle.
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    checkOutput("creditNoReady", 32'(reqReady), 32'h0);
    checkOutput("creditNoLpValid", 32'(lpValidMatch), 32'd0);
    nextCycle();
    checkOutput("creditHeld", 32'(outstanding), 32'd8);
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b1, 7'd20, 7'd10, 8'hA0);
    checkOutput("creditSameCycle", 32'(reqReady), 32'h0);
    nextCycle();
    checkOutput("creditResValid", 32'(resValid), 32'd1);
    checkOutput("creditResId", 32'(resId), 32'd0);
    checkOutput("creditResOffset", 32'(resOffset), 32'd20);
    checkOutput("creditSeven", 32'(outstanding), 32'd7);
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    checkOutput("creditResume", 32'(reqReady), 32'h1);
    nextCycle();
    checkOutput("creditRefill", 32'(outstanding), 32'd8);

    // Drain: tags are lanes 1,2,3,0,1,2,3,0 in issue order.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'h0, 1'b0, 1'b0, 1'b1, 7'(i), 7'd0, 8'd0);
      nextCycle();
      checkOutput("drainResValid", 32'(resValid), 32'd1);
      checkOutput("drainResId", 32'(resId), 32'((i + 1) % 4));
      checkOutput("drainResOffset", 32'(resOffset), 32'(i));
    end
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    nextCycle();
    checkOutput("drainEmpty", 32'(outstanding), 32'd0);
    checkOutput("drainResClear", 32'(resValid), 32'd0);

    // Back-pressure for 5 cycles, then resume at the saved pointer (lane 1).
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'hF, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
      checkOutput("bpNoReady", 32'(reqReady), 32'h0);
      nextCycle();
    end
    checkOutput("bpNoIssue", 32'(outstanding), 32'd0);
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    checkOutput("bpResume", 32'(reqReady), 32'h2);
    nextCycle();
    applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    checkOutput("rrSkip", 32'(reqReady), 32'h8);
    nextCycle();
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    checkOutput("rrWrap", 32'(reqReady), 32'h4);
    nextCycle();
    checkOutput("flushPreCount", 32'(outstanding), 32'd3);

    // Flush with 3 outstanding (lanes 1,3,2): no grants until drained.
    applyStimulus(4'h0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0, 8'd0);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'hF, 1'b0, 1'b0, 1'b1, 7'(30 + i), 7'd0, 8'd0);
      checkOutput("flushNoGrant", 32'(reqReady), 32'h0);
      nextCycle();
      checkOutput("flushResId", 32'(resId), (i == 0) ? 32'd1 : (i == 1) ? 32'd3 : 32'd2);
      checkOutput("flushCount", 32'(outstanding), 32'(2 - i));
      checkOutput("flushNotDone", 32'(flushDone), 32'd0);
    end
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    checkOutput("flushStillBlocked", 32'(reqReady), 32'h0);
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    nextCycle();
    checkOutput("flushDonePulse", 32'(flushDone), 32'd1);
    checkOutput("flushBusy", 32'(busy), 32'd0);
    nextCycle();
    checkOutput("flushDoneClear", 32'(flushDone), 32'd0);

    // Orphan result with an empty tag FIFO: sticky error, no result.
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b1, 7'd5, 7'd5, 8'd5);
    nextCycle();
    checkOutput("orphanSet", 32'(errOrphan), 32'd1);
    checkOutput("orphanNoRes", 32'(resValid), 32'd0);
    checkOutput("orphanCount", 32'(outstanding), 32'd0);
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    nextCycle();
    checkOutput("orphanSticky", 32'(errOrphan), 32'd1);

    // Flush while idle acknowledges on the next cycle.
    applyStimulus(4'h0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0, 8'd0);
    nextCycle();
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    checkOutput("idleFlushDone", 32'(flushDone), 32'd1);
    nextCycle();
    checkOutput("idleFlushClear", 32'(flushDone), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
